shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, data/result width in bits; legal values are powers of two, at least 8.
REQ-002 Parameter AMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 funct  input  6  MIPS R-type funct field selecting the operation.
REQ-007 data_in  input  WIDTH  operand to be shifted.
REQ-008 shamt  input  AMT_W  immediate shift amount (instruction field).
REQ-009 rs_amt  input  AMT_W  variable shift amount (low bits of register rs).
REQ-010 busy  output  1  high while an operation is in SHIFT or DONE.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 illegal  output  1  one-cycle pulse; rejected funct.
REQ-013 result  output  WIDTH  shifted value; held until the next accepted start.

Function
REQ-014 Decode: funct[5:3] SHALL be 000, otherwise the request is illegal; funct[1:0] = 00 sll, 10 srl, 11 sra, 01 rotr.
REQ-015 Amount source: funct[2]=0 selects shamt, funct[2]=1 selects rs_amt (sllv/srlv/srav/rotrv).
REQ-016 FSM states: IDLE, SHIFT, DONE; the reset state is IDLE.
REQ-017 IDLE, start=1, legal funct, amount>0: latch data_in, op and amount into internal registers; go to SHIFT.
REQ-018 IDLE, start=1, legal funct, amount=0: result <= data_in; go to DONE.
REQ-019 IDLE, start=1, illegal funct: illegal=1 next cycle for one cycle; result unchanged; stay IDLE.
REQ-020 SHIFT: each cycle, shift the working register by exactly one bit and decrement the counter.
REQ-021 SHIFT one-bit rules: sll fills 0 at LSB; srl fills 0 at MSB; sra replicates the MSB; rotr moves the LSB into the MSB.
REQ-022 SHIFT, counter reaching 0 on this edge: result <= final working value; go to DONE.
REQ-023 DONE: done=1 for exactly one cycle; go to IDLE unconditionally.
REQ-024 Latency: with amount N, done SHALL be high in the (N+1)th cycle after the start sample edge; N=0 gives 1 cycle; N=WIDTH-1 gives WIDTH cycles.
REQ-025 start while busy=1 (SHIFT or DONE) SHALL be ignored, not queued; inputs are not resampled.
REQ-026 data_in, funct, shamt and rs_amt are don't-care outside the start sample cycle.
REQ-027 busy=1 exactly in SHIFT and DONE; done and illegal are never high simultaneously.

Reset
REQ-028 reset=1 SHALL immediately force state to IDLE, result to 0, busy, done and illegal to 0, and counter and working register to 0.
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after deassertion is accepted normally.

Structure
REQ-030 A shared package shift_pkg SHALL hold the op enum (OP_SLL, OP_SRL, OP_SRA, OP_ROTR), the FSM state enum, and the funct constants 000000, 000010, 000011, 000001, 000100, 000110, 000111, 000101.
REQ-031 Decoding SHALL live in one combinational sub-module shift_funct_decode: inputs funct; outputs op, var_sel, illegal.
REQ-032 The datapath SHALL be a single WIDTH-bit working register plus an AMT_W-bit down-counter; there SHALL be no barrel shifter.

Verification
REQ-033 sll: WIDTH=32, funct=000000, shamt=4, data_in=0x0000_00F1 -> done 5 cycles after start, result=0x0000_0F10.
REQ-034 srav: funct=000111, rs_amt=8, shamt=3, data_in=0x8000_1234 -> uses 8; result=0xFF80_0012 after 9 cycles.
REQ-035 rotr / zero amount: funct=000001, shamt=1, data_in=0x0000_0001 -> result=0x8000_0000 after 2 cycles; shamt=0 -> result=data_in and done after 1 cycle.
REQ-036 Illegal / busy: funct=100000 -> single illegal pulse, busy stays 0, result unchanged; a second start during SHIFT of a 31-bit srl -> ignored; one done after 32 cycles, result=0x0000_0001 for data_in=0x8000_0000.
REQ-037 Reset mid-op: reset asserted at cycle 3 of a shamt=20 sll -> busy, done and result drop to 0 asynchronously; no done pulse; a following shamt=2 op completes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and funct constants for the serial shift sequencer.
// Imported by the decoder and the sequencer top.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_ROTR = 2'b01,
        OP_SRL  = 2'b10,
        OP_SRA  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_ROTR  = 6'b000001;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_ROTRV = 6'b000101;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;

endpackage

// File: rtl/shift_funct_decode.sv
// MIPS R-type shift funct decoder.
// Pure combinational: op, amount source and legality.
module shift_funct_decode
    import shift_pkg::*;
(
    input  logic [5:0] funct,
    output op_t        op,
    output logic       var_sel,
    output logic       illegal
);

    // Map each legal funct onto op and amount source; anything else is illegal
    always_comb begin
        op      = OP_SLL;
        var_sel = 1'b0;
        illegal = 1'b0;
        unique case (funct)
            FN_SLL:   op = OP_SLL;
            FN_SRL:   op = OP_SRL;
            FN_SRA:   op = OP_SRA;
            FN_ROTR:  op = OP_ROTR;
            FN_SLLV: begin
                op      = OP_SLL;
                var_sel = 1'b1;
            end
            FN_SRLV: begin
                op      = OP_SRL;
                var_sel = 1'b1;
            end
            FN_SRAV: begin
                op      = OP_SRA;
                var_sel = 1'b1;
            end
            FN_ROTRV: begin
                op      = OP_ROTR;
                var_sel = 1'b1;
            end
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Bit-serial shifter: one bit per cycle through a single working
// register and a down-counter, sequenced by an IDLE/SHIFT/DONE FSM.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] shamt,
    input  logic [AMT_W-1:0] rs_amt,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] result
);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               illegal_q, illegal_d;

    op_t                dec_op;
    logic               dec_var;
    logic               dec_ill;
    logic [AMT_W-1:0]   amt;
    logic [WIDTH-1:0]   shifted;

    shift_funct_decode u_dec (
        .funct   (funct),
        .op      (dec_op),
        .var_sel (dec_var),
        .illegal (dec_ill)
    );

    assign amt = dec_var ? rs_amt : shamt;

    // One-bit step of the working register for the latched op
    always_comb begin
        shifted = work_q;
        unique case (op_q)
            OP_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            OP_ROTR: shifted = {work_q[0], work_q[WIDTH-1:1]};
            default: shifted = work_q;
        endcase
    end

    // Next-state and datapath update decisions
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        illegal_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dec_ill) begin
                        illegal_d = 1'b1;
                    end else if (amt != '0) begin
                        work_d  = data_in;
                        op_d    = dec_op;
                        cnt_d   = amt;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d = data_in;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    result_d = shifted;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_SLL;
            work_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign illegal = illegal_q;
    assign result  = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (WIDTH=32).
// Each task drives one scenario and checks its own expectations.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] data_in = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic [4:0]  rs_amt = 5'd0;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    shift_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct   (funct),
        .data_in (data_in),
        .shamt   (shamt),
        .rs_amt  (rs_amt),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .result  (result)
    );

    always #5 clk = ~clk;

    // Pulse start across one sampling edge; returns #1 after that edge
    task automatic start_op(input logic [5:0] f, input logic [31:0] d,
                            input logic [4:0] sa, input logic [4:0] ra);
        funct   = f;
        data_in = d;
        shamt   = sa;
        rs_amt  = ra;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        funct   = 6'b111111;
        data_in = 32'hA5A5_A5A5;
    endtask

    // Cycle index (1 = first cycle after sampling edge) where done shows
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Run one op, check latency, result and one-cycle done pulse
    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] d, input logic [4:0] sa,
                          input logic [4:0] ra, input int exp_lat,
                          input logic [31:0] exp_res);
        int lat;
        start_op(f, d, sa, ra);
        wait_done(lat);
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        checks++;
        if (result !== exp_res) begin
            failures++;
            $display("FAIL %s_result got=%h exp=%h", name, result, exp_res);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse done=%b busy=%b exp=0,0",
                     name, done, busy);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b illegal=%b exp=0",
                     busy, done, illegal);
        end
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0", result);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sll();
        run_op("sll", 6'b000000, 32'h0000_00F1, 5'd4, 5'd9,
               5, 32'h0000_0F10);
    endtask

    task automatic test_srav();
        run_op("srav", 6'b000111, 32'h8000_1234, 5'd3, 5'd8,
               9, 32'hFF80_0012);
    endtask

    task automatic test_rotr();
        run_op("rotr", 6'b000001, 32'h0000_0001, 5'd1, 5'd0,
               2, 32'h8000_0000);
    endtask

    task automatic test_zero_amount();
        run_op("zero", 6'b000001, 32'hDEAD_BEEF, 5'd0, 5'd7,
               1, 32'hDEAD_BEEF);
    endtask

    task automatic test_illegal();
        start_op(6'b100000, 32'h1234_5678, 5'd3, 5'd3);
        checks++;
        if (illegal !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse illegal=%b busy=%b done=%b exp=1,0,0",
                     illegal, busy, done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (illegal !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL illegal_width illegal=%b busy=%b exp=0,0",
                     illegal, busy);
        end
        checks++;
        if (result !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL illegal_result got=%h exp=deadbeef", result);
        end
    endtask

    task automatic test_busy_ignore();
        int first;
        int pulses;
        logic saw_busy;
        first = 0;
        pulses = 0;
        saw_busy = 1'b1;
        start_op(6'b000010, 32'h8000_0000, 5'd31, 5'd0);
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) begin
                funct   = 6'b000000;
                data_in = 32'h0000_FFFF;
                shamt   = 5'd1;
                start   = 1'b1;
            end
            if (k == 6) start = 1'b0;
            if (k < 32 && busy !== 1'b1) saw_busy = 1'b0;
            if (done) begin
                pulses++;
                if (first == 0) first = k;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++;
        if (!saw_busy) begin
            failures++;
            $display("FAIL busy_level got=0 exp=1 during shift");
        end
        checks++;
        if (pulses != 1 || first != 32) begin
            failures++;
            $display("FAIL busy_done pulses=%0d at=%0d exp=1 at 32",
                     pulses, first);
        end
        checks++;
        if (result !== 32'h0000_0001) begin
            failures++;
            $display("FAIL busy_result got=%h exp=00000001", result);
        end
    endtask

    task automatic test_back_to_back();
        run_op("sllv", 6'b000100, 32'h0000_0011, 5'd0, 5'd3,
               4, 32'h0000_0088);
        run_op("srl", 6'b000010, 32'hF000_0000, 5'd4, 5'd0,
               5, 32'h0F00_0000);
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        start_op(6'b000000, 32'h0000_0001, 5'd20, 5'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_busy_before got=%b exp=1", busy);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_async busy=%b done=%b result=%h exp=0",
                     busy, done, result);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL rst_mid_nodone pulses=%0d exp=0", pulses);
        end
        run_op("rst_after", 6'b000000, 32'h0000_0003, 5'd2, 5'd0,
               3, 32'h0000_000C);
    endtask

    initial begin
        test_reset();
        test_sll();
        test_srav();
        test_rotr();
        test_zero_amount();
        test_illegal();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
